// File: rtl/conv_result_framer.sv
// Frames NUM_RESULTS snapshotted result bytes as SYNC, LEN, payload, CHECK and hands them to a uart_tx.
// Define FRAMER_CRC8_EN to make CHECK a CRC-8 (poly 0x07); otherwise CHECK is the additive mod-256 sum.
module conv_result_framer #(
    parameter int unsigned NUM_RESULTS = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned GAP_CYCLES  = 12,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [NUM_RESULTS*8-1:0] results_flat_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     tx_start_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_busy_i
);

    localparam int unsigned CNT_MAX  = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [8:0]  LAST_IDX = 9'(NUM_RESULTS + 2);
    localparam logic [7:0]  LEN_BYTE = 8'(NUM_RESULTS);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_TX,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [8:0]               idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               chk_q, chk_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic [NUM_RESULTS*8-1:0] buf_q, buf_d;
    logic                     tx_start_c;
    logic                     done_c;

    logic [8:0] nidx;
    logic [7:0] poff;
    logic [7:0] payload_byte;
    logic [7:0] next_byte;

`ifdef FRAMER_CRC8_EN
    function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`else
    function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] b);
        return c + b;
    endfunction
`endif

    // Byte that follows the current index; CHECK comes from the running accumulator.
    always_comb begin
        nidx         = idx_q + 9'd1;
        poff         = nidx[7:0] - 8'd2;
        payload_byte = '0;
        for (int k = 0; k < int'(NUM_RESULTS); k++) begin
            if (poff == 8'(k)) payload_byte = buf_q[8*k +: 8];
        end
        if (nidx == 9'd1)          next_byte = LEN_BYTE;
        else if (nidx < LAST_IDX)  next_byte = payload_byte;
        else                       next_byte = chk_q;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        tx_data_d  = tx_data_q;
        buf_d      = buf_q;
        tx_start_c = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    buf_d   = results_flat_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d     = '0;
                chk_d     = '0;
                tx_data_d = SYNC_BYTE;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy_i) begin
                    tx_start_c = 1'b1;
                    cnt_d      = ACK_LOAD;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Accumulate on acknowledge so a re-issued byte is counted once.
                if (tx_busy_i) begin
                    state_d = S_WAIT_TX;
                    if (idx_q != 9'd0 && idx_q != LAST_IDX) chk_d = chk_step(chk_q, tx_data_q);
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_TX: begin
                if (!tx_busy_i) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = nidx;
                        tx_data_d = next_byte;
                        state_d   = S_SEND;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            tx_data_q <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            tx_data_q <= tx_data_d;
            buf_q     <= buf_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_c;
    assign tx_start_o = tx_start_c;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_conv_result_framer.sv
// Self-checking bench for conv_result_framer with a behavioural uart_tx model and frame reference model.
// Build with FRAMER_CRC8_EN defined to also exercise the CRC-8 CHECK variant.
module tb_conv_result_framer;

    localparam int N    = 10;
    localparam int GAP  = 12;
    localparam int ACK  = 16;
    localparam int FLEN = N + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N*8-1:0] results_flat = '0;
    logic           busy, done, tx_start, tx_busy;
    logic [7:0]     tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    conv_result_framer #(
        .NUM_RESULTS(N), .SYNC_BYTE(8'hA5), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .results_flat_i(results_flat),
        .busy_o(busy), .done_o(done), .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy)
    );

    // uart_tx model: busy from the cycle after an accepted tx_start for 100 cycles
    int busy_left = 0;
    int cyc       = 0;
    int fall_cyc  = -1000;
    int pulses    = 0;
    int drop_req  = 0;
    int drop_done = 0;
    int viol      = 0;
    logic [7:0] sent[$];
    int gaps[$];
    int pulse_cyc[$];

    assign tx_busy = (busy_left != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy_left == 1) fall_cyc <= cyc + 1;
        if (busy_left != 0) busy_left <= busy_left - 1;
        if (tx_start) begin
            pulses <= pulses + 1;
            pulse_cyc.push_back(cyc);
            if (tx_busy) viol <= viol + 1;
            if (drop_done < drop_req) begin
                drop_done <= drop_done + 1;
            end else begin
                busy_left <= 100;
                sent.push_back(tx_data);
                gaps.push_back(cyc - fall_cyc);
            end
        end
    end

`ifdef FRAMER_CRC8_EN
    logic       start1 = 1'b0;
    logic [7:0] rf1 = '0;
    logic       busy1, done1, tx_start1, tx_busy1;
    logic [7:0] tx_data1;
    int         busy_left1 = 0;
    logic [7:0] sent1[$];

    conv_result_framer #(
        .NUM_RESULTS(1), .SYNC_BYTE(8'hA5), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .results_flat_i(rf1),
        .busy_o(busy1), .done_o(done1), .tx_start_o(tx_start1), .tx_data_o(tx_data1),
        .tx_busy_i(tx_busy1)
    );

    assign tx_busy1 = (busy_left1 != 0);

    always @(posedge clk) begin
        if (busy_left1 != 0) busy_left1 <= busy_left1 - 1;
        if (tx_start1) begin
            busy_left1 <= 100;
            sent1.push_back(tx_data1);
        end
    end
`endif

    // Reference frame built straight from the framing rules
    logic [7:0] exp_f [FLEN];

    task automatic model_frame(input logic [N*8-1:0] r);
        int sum;
        logic [7:0] crc;
        logic fb;
        exp_f[0] = 8'hA5;
        exp_f[1] = 8'(N);
        for (int k = 0; k < N; k++) exp_f[2+k] = r[8*k +: 8];
        sum = 0;
        crc = 8'h00;
        for (int i = 1; i <= N + 1; i++) begin
            sum = (sum + int'(exp_f[i])) % 256;
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ exp_f[i][b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`ifdef FRAMER_CRC8_EN
        exp_f[N+2] = crc;
`else
        exp_f[N+2] = 8'(sum);
`endif
    endtask

    function automatic logic [N*8-1:0] rand_results();
        logic [N*8-1:0] r;
        for (int k = 0; k < N; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic pulse_start(input logic [N*8-1:0] r);
        @(negedge clk);
        results_flat = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int ndone;
        ndone = 0;
        for (int t = 0; t < 4000 && ndone == 0; t++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone == 0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done pulses=%0d required=1", name, ndone);
        end
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d required 1", name, ndone);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after: got %b required 0", name, busy);
        end
    endtask

    task automatic check_frame(input string name, input int base);
        logic [7:0] a;
        n_checks++;
        if (sent.size() - base != FLEN) begin
            n_fail++;
            $display("FAIL %s_len: got %0d bytes required %0d", name, sent.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            a = (base + i < sent.size()) ? sent[base+i] : 8'hxx;
            n_checks++;
            if (a !== exp_f[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h required %h", name, i, a, exp_f[i]);
            end
        end
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, tx_start} !== 3'b000 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b tx_start=%b tx_data=%h required 0 0 0 00",
                     busy, done, tx_start, tx_data);
        end
        rst = 1'b0;
        p0 = pulses;
        repeat (50) @(negedge clk);
        n_checks++;
        if (pulses != p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d pulses busy=%b required 0 pulses busy=0", pulses - p0, busy);
        end
    endtask

    task automatic test_basic();
        logic [N*8-1:0] r;
        int base, p0;
        for (int k = 0; k < N; k++) r[8*k +: 8] = 8'(k + 1);
        model_frame(r);
        base = sent.size();
        p0 = pulses;
        pulse_start(r);
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_start: got tx_start=%b tx_data=%h busy=%b required 1 a5 1",
                     tx_start, tx_data, busy);
        end
        wait_done("basic");
        check_frame("basic", base);
        n_checks++;
        if (pulses - p0 != FLEN) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d required %0d", pulses - p0, FLEN);
        end
`ifndef FRAMER_CRC8_EN
        n_checks++;
        if (sent.size() < base + FLEN || sent[base+FLEN-1] !== 8'h41) begin
            n_fail++;
            $display("FAIL basic_check_literal: got %h required 41",
                     (sent.size() >= base + FLEN) ? sent[base+FLEN-1] : 8'hxx);
        end
`endif
    endtask

    task automatic test_all_ff();
        logic [N*8-1:0] r;
        int base;
        r = '1;
        model_frame(r);
        base = sent.size();
        pulse_start(r);
        wait_done("allff");
        check_frame("allff", base);
`ifndef FRAMER_CRC8_EN
        n_checks++;
        if (sent.size() < base + FLEN || sent[base+FLEN-1] !== 8'h00) begin
            n_fail++;
            $display("FAIL allff_check_literal: got %h required 00",
                     (sent.size() >= base + FLEN) ? sent[base+FLEN-1] : 8'hxx);
        end
`endif
    endtask

    task automatic test_start_ignored();
        logic [N*8-1:0] r, r2;
        int base, p0;
        r  = rand_results();
        r2 = ~r;
        model_frame(r);
        base = sent.size();
        p0 = pulses;
        pulse_start(r);
        repeat (300) @(negedge clk);
        pulse_start(r2);
        results_flat = rand_results();
        repeat (200) @(negedge clk);
        results_flat = r2;
        wait_done("ignore");
        check_frame("ignore", base);
        n_checks++;
        if (pulses - p0 != FLEN) begin
            n_fail++;
            $display("FAIL ignore_pulses: got %0d required %0d", pulses - p0, FLEN);
        end
    endtask

    task automatic test_ack_timeout();
        logic [N*8-1:0] r;
        int base, p0, dt, gmin;
        r = rand_results();
        model_frame(r);
        base = sent.size();
        p0 = pulses;
        drop_req = drop_req + 1;
        pulse_start(r);
        wait_done("ackto");
        check_frame("ackto", base);
        n_checks++;
        if (pulses - p0 != FLEN + 1) begin
            n_fail++;
            $display("FAIL ackto_pulses: got %0d required %0d", pulses - p0, FLEN + 1);
        end
        dt = (pulse_cyc.size() > p0 + 1) ? pulse_cyc[p0+1] - pulse_cyc[p0] : -1;
        n_checks++;
        if (dt < ACK || dt > ACK + 2) begin
            n_fail++;
            $display("FAIL ackto_reissue_delay: got %0d cycles required %0d..%0d", dt, ACK, ACK + 2);
        end
        gmin = 1000000;
        for (int i = 1; i < FLEN; i++) begin
            if (base + i < gaps.size() && gaps[base+i] < gmin) gmin = gaps[base+i];
        end
        n_checks++;
        if (gmin < GAP) begin
            n_fail++;
            $display("FAIL ackto_min_gap: got %0d idle cycles required >= %0d", gmin, GAP);
        end
    endtask

    task automatic test_mid_reset();
        logic [N*8-1:0] r, r2;
        int base, p1, t;
        r = rand_results();
        base = sent.size();
        pulse_start(r);
        for (t = 0; t < 3000 && (sent.size() - base) < 7; t++) @(negedge clk);
        n_checks++;
        if ((sent.size() - base) < 7) begin
            n_fail++;
            $display("FAIL midrst_reach_byte: got %0d bytes required 7", sent.size() - base);
        end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, tx_start} !== 3'b000 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: got busy=%b done=%b tx_start=%b tx_data=%h required 0 0 0 00",
                     busy, done, tx_start, tx_data);
        end
        rst = 1'b0;
        p1 = pulses;
        repeat (150) @(negedge clk);
        n_checks++;
        if (pulses != p1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_resend: got %0d pulses busy=%b required 0 pulses busy=0", pulses - p1, busy);
        end
        r2 = rand_results();
        model_frame(r2);
        base = sent.size();
        pulse_start(r2);
        wait_done("midrst");
        check_frame("midrst", base);
    endtask

    task automatic test_random();
        int base;
        for (int it = 0; it < 3; it++) begin
            logic [N*8-1:0] r;
            r = rand_results();
            model_frame(r);
            base = sent.size();
            pulse_start(r);
            wait_done("random");
            check_frame("random", base);
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL tx_start_while_busy: got %0d required 0", viol);
        end
    endtask

`ifdef FRAMER_CRC8_EN
    task automatic test_crc8_single();
        logic [7:0] want [4];
        logic [7:0] a;
        int t;
        want[0] = 8'hA5; want[1] = 8'h01; want[2] = 8'h00; want[3] = 8'h15;
        @(negedge clk);
        rf1 = 8'h00;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (t = 0; t < 2000 && done1 !== 1'b1; t++) @(negedge clk);
        n_checks++;
        if (sent1.size() != 4) begin
            n_fail++;
            $display("FAIL crc8_len: got %0d bytes required 4", sent1.size());
        end
        for (int i = 0; i < 4; i++) begin
            a = (i < sent1.size()) ? sent1[i] : 8'hxx;
            n_checks++;
            if (a !== want[i]) begin
                n_fail++;
                $display("FAIL crc8_byte%0d: got %h required %h", i, a, want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_all_ff();
        test_start_ignored();
        test_ack_timeout();
        test_mid_reset();
        test_random();
`ifdef FRAMER_CRC8_EN
        test_crc8_single();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
